// File: rtl/mem_arbiter.sv
// Shares one 32x8 single-port memory between a read-only fetch port and a
// read/write data port. Owns the memory enables, address and data bus.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int READ_LAT    = 1,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  input  logic                  dx_req,
  input  logic                  dx_we,
  input  logic [ADDR_WIDTH-1:0] dx_addr,
  input  logic [DATA_WIDTH-1:0] dx_wdata,
  output logic                  dx_gnt,
  output logic [DATA_WIDTH-1:0] dx_rdata,
  output logic                  dx_rvalid,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, TA} state_t;

  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  state_t                state;
  state_t                state_next;
  logic [1:0]            rd_cnt;
  logic                  sel_dx;
  logic                  last_dx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  win_if;
  logic                  win_dx;
  logic                  rd_done;

  // The bus enable is the one output decoded straight from state, so the
  // driver releases on exactly the edge that leaves WR (including reset).
  assign mem_data = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    win_if     = 1'b0;
    win_dx     = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        // On contention dx wins unless round-robin says it won last time.
        if (dx_req && (!if_req || !ROUND_ROBIN || !last_dx)) begin
          win_dx     = 1'b1;
          state_next = dx_we ? WR : RD;
        end else if (if_req) begin
          win_if     = 1'b1;
          state_next = RD;
        end
      end
      RD: begin
        if (rd_cnt == LAST_CNT) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      WR:      state_next = TA;
      TA:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      sel_dx       <= 1'b0;
      last_dx      <= 1'b0;
      wdata_q      <= '0;
      if_gnt       <= 1'b0;
      dx_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      dx_rvalid    <= 1'b0;
      if_rdata     <= '0;
      dx_rdata     <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_address  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      if_gnt       <= win_if;
      dx_gnt       <= win_dx;
      if_rvalid    <= rd_done && !sel_dx;
      dx_rvalid    <= rd_done && sel_dx;
      mem_read_en  <= (state_next == RD);
      mem_write_en <= (state_next == WR);
      busy         <= (state_next != IDLE);

      if (win_if || win_dx) begin
        mem_address <= win_dx ? dx_addr : if_addr;
        sel_dx      <= win_dx;
        last_dx     <= win_dx;
        wdata_q     <= dx_wdata;
        rd_cnt      <= '0;
      end else if (state == RD) begin
        rd_cnt <= rd_cnt + 2'd1;
      end

      // The memory drives the bus for the whole RD window; take it on the last edge.
      if (rd_done) begin
        if (sel_dx) dx_rdata <= mem_data;
        else        if_rdata <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is READ_LAT=1 fixed priority, instance 1
// is READ_LAT=3 round-robin; each has its own behavioural 32x8 memory.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req      [2];
  logic [AW-1:0] if_addr     [2];
  logic          if_gnt      [2];
  logic [DW-1:0] if_rdata    [2];
  logic          if_rvalid   [2];
  logic          dx_req      [2];
  logic          dx_we       [2];
  logic [AW-1:0] dx_addr     [2];
  logic [DW-1:0] dx_wdata    [2];
  logic          dx_gnt      [2];
  logic [DW-1:0] dx_rdata    [2];
  logic          dx_rvalid   [2];
  logic          mem_read_en [2];
  logic          mem_write_en[2];
  logic [AW-1:0] mem_address [2];
  logic          busy        [2];
  logic [DW-1:0] bus         [2];

  int            compared   = 0;
  int            mismatched = 0;
  logic [DW-1:0] shadow [2][32];
  op_t           if_ops[$];
  op_t           dx_ops[$];
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dx[$];
  bit            grant_log[$];
  int            gnt_cyc[$];
  int            overlap;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return 8'((a * 37 + 54) % 256);
  endfunction

  function automatic op_t mk_op(input logic we, input int addr, input int wdata);
    op_t o;
    o.we    = we;
    o.addr  = 5'(addr);
    o.wdata = 8'(wdata);
    return o;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    wire  [DW-1:0] mem_data;
    logic [DW-1:0] mem [32];

    // The memory drives during reads; the bench parks the bus at zero when
    // neither enable is high, so a stray arbiter drive shows as non-zero or X.
    assign mem_data = mem_read_en[g] ? mem[mem_address[g]] :
                      (!mem_write_en[g] ? {DW{1'b0}} : {DW{1'bz}});
    assign bus[g] = mem_data;

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      end else if (mem_write_en[g]) begin
        mem[mem_address[g]] <= mem_data;
      end
    end

    mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .READ_LAT   ((g == 0) ? 1 : 3),
      .ROUND_ROBIN((g == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req[g]),
      .if_addr     (if_addr[g]),
      .if_gnt      (if_gnt[g]),
      .if_rdata    (if_rdata[g]),
      .if_rvalid   (if_rvalid[g]),
      .dx_req      (dx_req[g]),
      .dx_we       (dx_we[g]),
      .dx_addr     (dx_addr[g]),
      .dx_wdata    (dx_wdata[g]),
      .dx_gnt      (dx_gnt[g]),
      .dx_rdata    (dx_rdata[g]),
      .dx_rvalid   (dx_rvalid[g]),
      .mem_read_en (mem_read_en[g]),
      .mem_write_en(mem_write_en[g]),
      .mem_address (mem_address[g]),
      .mem_data    (mem_data),
      .busy        (busy[g])
    );
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      if_req[n]   = 1'b0;
      if_addr[n]  = '0;
      dx_req[n]   = 1'b0;
      dx_we[n]    = 1'b0;
      dx_addr[n]  = '0;
      dx_wdata[n] = '0;
      for (int a = 0; a < 32; a++) shadow[n][a] = init_val(a);
    end
    if_ops.delete();
    dx_ops.delete();
    exp_if.delete();
    exp_dx.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester model: holds req, reloads the next op on the gnt cycle (so req
  // stays high for back-to-back traffic), and checks rvalid data in order.
  task automatic run_ops(input int n, input int budget);
    op_t           cur_if;
    op_t           cur_dx;
    logic [DW-1:0] e;
    int            cyc = 0;
    overlap = 0;
    grant_log.delete();
    gnt_cyc.delete();
    @(negedge clk);
    if (if_ops.size() > 0) begin
      cur_if     = if_ops.pop_front();
      if_addr[n] = cur_if.addr;
      if_req[n]  = 1'b1;
    end
    if (dx_ops.size() > 0) begin
      cur_dx      = dx_ops.pop_front();
      dx_we[n]    = cur_dx.we;
      dx_addr[n]  = cur_dx.addr;
      dx_wdata[n] = cur_dx.wdata;
      dx_req[n]   = 1'b1;
    end
    while ((if_req[n] || dx_req[n] || busy[n] || exp_if.size() > 0 || exp_dx.size() > 0)
           && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (mem_read_en[n] && mem_write_en[n]) overlap++;
      if (if_rvalid[n]) begin
        compared++;
        if (exp_if.size() == 0) begin
          mismatched++;
          $display("FAIL if_rdata[%0d]: unexpected rvalid with %h, expected none", n, if_rdata[n]);
        end else begin
          e = exp_if.pop_front();
          if (if_rdata[n] !== e) begin
            mismatched++;
            $display("FAIL if_rdata[%0d]: got %h expected %h", n, if_rdata[n], e);
          end
        end
      end
      if (dx_rvalid[n]) begin
        compared++;
        if (exp_dx.size() == 0) begin
          mismatched++;
          $display("FAIL dx_rdata[%0d]: unexpected rvalid with %h, expected none", n, dx_rdata[n]);
        end else begin
          e = exp_dx.pop_front();
          if (dx_rdata[n] !== e) begin
            mismatched++;
            $display("FAIL dx_rdata[%0d]: got %h expected %h", n, dx_rdata[n], e);
          end
        end
      end
      if (if_gnt[n]) begin
        grant_log.push_back(1'b0);
        gnt_cyc.push_back(cyc);
        exp_if.push_back(shadow[n][cur_if.addr]);
        if (if_ops.size() > 0) begin
          cur_if     = if_ops.pop_front();
          if_addr[n] = cur_if.addr;
        end else begin
          if_req[n] = 1'b0;
        end
      end
      if (dx_gnt[n]) begin
        grant_log.push_back(1'b1);
        gnt_cyc.push_back(cyc);
        if (cur_dx.we) shadow[n][cur_dx.addr] = cur_dx.wdata;
        else           exp_dx.push_back(shadow[n][cur_dx.addr]);
        if (dx_ops.size() > 0) begin
          cur_dx      = dx_ops.pop_front();
          dx_we[n]    = cur_dx.we;
          dx_addr[n]  = cur_dx.addr;
          dx_wdata[n] = cur_dx.wdata;
        end else begin
          dx_req[n] = 1'b0;
        end
      end
    end
    if_req[n] = 1'b0;
    dx_req[n] = 1'b0;
    compared++;
    if (cyc >= budget) begin
      mismatched++;
      $display("FAIL run_ops[%0d] timeout: got %0d cycles, required < %0d", n, cyc, budget);
    end
    compared++;
    if (overlap !== 0) begin
      mismatched++;
      $display("FAIL enable_overlap[%0d]: got %0d cycles, expected 0", n, overlap);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      compared++;
      if ({if_gnt[n], dx_gnt[n], if_rvalid[n], dx_rvalid[n], mem_read_en[n],
           mem_write_en[n], busy[n]} !== 7'b0) begin
        mismatched++;
        $display("FAIL reset_ctrl[%0d]: got %b expected 0000000", n,
                 {if_gnt[n], dx_gnt[n], if_rvalid[n], dx_rvalid[n], mem_read_en[n],
                  mem_write_en[n], busy[n]});
      end
      compared++;
      if (mem_address[n] !== 5'd0) begin
        mismatched++;
        $display("FAIL reset_addr[%0d]: got %h expected 00", n, mem_address[n]);
      end
      compared++;
      if ({if_rdata[n], dx_rdata[n]} !== 16'h0000) begin
        mismatched++;
        $display("FAIL reset_rdata[%0d]: got %h expected 0000", n, {if_rdata[n], dx_rdata[n]});
      end
      compared++;
      if (bus[n] !== 8'h00) begin
        mismatched++;
        $display("FAIL reset_bus[%0d]: got %h expected released (00)", n, bus[n]);
      end
    end
  endtask

  task automatic test_single_fetch();
    logic [DW-1:0] e;
    apply_reset();
    @(negedge clk);
    if_addr[0] = 5'd3;
    if_req[0]  = 1'b1;
    exp_if.push_back(shadow[0][3]);
    @(negedge clk);
    compared++;
    if ({mem_read_en[0], mem_address[0], if_gnt[0], busy[0]} !== {1'b1, 5'd3, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL fetch_grant: got ren=%b addr=%h gnt=%b busy=%b expected 1 03 1 1",
               mem_read_en[0], mem_address[0], if_gnt[0], busy[0]);
    end
    if_req[0] = 1'b0;
    @(negedge clk);
    e = exp_if.pop_front();
    compared++;
    if ({if_rvalid[0], if_rdata[0]} !== {1'b1, e}) begin
      mismatched++;
      $display("FAIL fetch_data: got rvalid=%b rdata=%h expected 1 %h", if_rvalid[0], if_rdata[0], e);
    end
    compared++;
    if ({mem_read_en[0], busy[0], if_gnt[0]} !== 3'b000) begin
      mismatched++;
      $display("FAIL fetch_idle: got %b expected 000", {mem_read_en[0], busy[0], if_gnt[0]});
    end
    @(negedge clk);
    compared++;
    if ({if_rvalid[0], if_rdata[0]} !== {1'b0, e}) begin
      mismatched++;
      $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 %h", if_rvalid[0], if_rdata[0], e);
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    @(negedge clk);
    dx_we[0]    = 1'b1;
    dx_addr[0]  = 5'd7;
    dx_wdata[0] = 8'h3C;
    dx_req[0]   = 1'b1;
    shadow[0][7] = 8'h3C;
    @(negedge clk);
    compared++;
    if ({mem_write_en[0], mem_read_en[0], mem_address[0], dx_gnt[0]} !== {1'b1, 1'b0, 5'd7, 1'b1}) begin
      mismatched++;
      $display("FAIL wr_cycle: got wen=%b ren=%b addr=%h gnt=%b expected 1 0 07 1",
               mem_write_en[0], mem_read_en[0], mem_address[0], dx_gnt[0]);
    end
    compared++;
    if (bus[0] !== 8'h3C) begin
      mismatched++;
      $display("FAIL wr_bus: got %h expected 3c", bus[0]);
    end
    dx_req[0] = 1'b0;
    dx_we[0]  = 1'b0;
    @(negedge clk);
    compared++;
    if ({mem_write_en[0], mem_read_en[0], busy[0], bus[0]} !== {3'b001, 8'h00}) begin
      mismatched++;
      $display("FAIL ta_cycle: got wen=%b ren=%b busy=%b bus=%h expected 0 0 1 00",
               mem_write_en[0], mem_read_en[0], busy[0], bus[0]);
    end
    @(negedge clk);
    compared++;
    if (busy[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL ta_exit: got busy=%b expected 0", busy[0]);
    end
    dx_ops.push_back(mk_op(1'b0, 7, 0));
    run_ops(0, 20);
  endtask

  task automatic test_contention(input int n);
    bit exp_ord[$];
    apply_reset();
    if (n == 0) begin
      dx_ops  = '{mk_op(1'b0, 10, 0), mk_op(1'b0, 11, 0), mk_op(1'b0, 12, 0)};
      if_ops  = '{mk_op(1'b0, 20, 0), mk_op(1'b0, 21, 0)};
      exp_ord = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    end else begin
      dx_ops  = '{mk_op(1'b0, 10, 0), mk_op(1'b0, 11, 0)};
      if_ops  = '{mk_op(1'b0, 20, 0), mk_op(1'b0, 21, 0)};
      exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    end
    run_ops(n, 80);
    compared++;
    if (grant_log.size() !== exp_ord.size()) begin
      mismatched++;
      $display("FAIL grant_count[%0d]: got %0d expected %0d", n, grant_log.size(), exp_ord.size());
    end else begin
      for (int i = 0; i < exp_ord.size(); i++) begin
        compared++;
        if (grant_log[i] !== exp_ord[i]) begin
          mismatched++;
          $display("FAIL grant_order[%0d][%0d]: got %s expected %s", n, i,
                   grant_log[i] ? "dx" : "if", exp_ord[i] ? "dx" : "if");
        end
      end
    end
  endtask

  task automatic test_read_lat3();
    logic [DW-1:0] e;
    logic [5:0]    ren_mask = '0;
    bit            addr_ok  = 1'b1;
    int            rv_at    = 0;
    apply_reset();
    @(negedge clk);
    if_addr[1] = 5'd31;
    if_req[1]  = 1'b1;
    exp_if.push_back(shadow[1][31]);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (if_gnt[1]) if_req[1] = 1'b0;
      ren_mask[c-1] = mem_read_en[1];
      if (mem_read_en[1] && mem_address[1] !== 5'd31) addr_ok = 1'b0;
      if (if_rvalid[1] && rv_at == 0) rv_at = c;
    end
    if_req[1] = 1'b0;
    e = exp_if.pop_front();
    compared++;
    if (ren_mask !== 6'b000111) begin
      mismatched++;
      $display("FAIL lat3_ren: got %b expected 000111", ren_mask);
    end
    compared++;
    if (!addr_ok) begin
      mismatched++;
      $display("FAIL lat3_addr: got unstable address expected 1f throughout");
    end
    compared++;
    if (rv_at !== 4) begin
      mismatched++;
      $display("FAIL lat3_rvalid_cycle: got %0d expected 4", rv_at);
    end
    compared++;
    if (if_rdata[1] !== e) begin
      mismatched++;
      $display("FAIL lat3_rdata: got %h expected %h", if_rdata[1], e);
    end
  endtask

  task automatic test_reset_mid_op();
    int stray = 0;
    apply_reset();
    @(negedge clk);
    if_addr[1] = 5'd5;
    if_req[1]  = 1'b1;
    @(negedge clk);
    if_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({mem_read_en[1], busy[1], if_rvalid[1]} !== 3'b000) begin
      mismatched++;
      $display("FAIL rst_mid_rd: got ren/busy/rvalid=%b expected 000",
               {mem_read_en[1], busy[1], if_rvalid[1]});
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (if_rvalid[1] || mem_read_en[1]) stray++;
    end
    compared++;
    if (stray !== 0) begin
      mismatched++;
      $display("FAIL rst_rd_after: got %0d active cycles expected 0", stray);
    end

    stray = 0;
    @(negedge clk);
    dx_we[0]    = 1'b1;
    dx_addr[0]  = 5'd9;
    dx_wdata[0] = 8'h77;
    dx_req[0]   = 1'b1;
    @(negedge clk);
    dx_req[0] = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    compared++;
    if ({mem_write_en[0], busy[0], bus[0]} !== {2'b00, 8'h00}) begin
      mismatched++;
      $display("FAIL rst_mid_wr: got wen=%b busy=%b bus=%h expected 0 0 00",
               mem_write_en[0], busy[0], bus[0]);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_write_en[0]) stray++;
    end
    compared++;
    if (stray !== 0) begin
      mismatched++;
      $display("FAIL rst_wr_after: got %0d write cycles expected 0", stray);
    end
  endtask

  task automatic test_back_to_back(input int n);
    int spacing;
    spacing = (n == 0) ? 2 : 4;
    apply_reset();
    if_ops = '{mk_op(1'b0, 0, 0), mk_op(1'b0, 1, 0), mk_op(1'b0, 2, 0)};
    run_ops(n, 60);
    compared++;
    if (gnt_cyc.size() !== 3) begin
      mismatched++;
      $display("FAIL b2b_grants[%0d]: got %0d expected 3", n, gnt_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        compared++;
        if (gnt_cyc[i] - gnt_cyc[i-1] !== spacing) begin
          mismatched++;
          $display("FAIL b2b_spacing[%0d][%0d]: got %0d expected %0d", n, i,
                   gnt_cyc[i] - gnt_cyc[i-1], spacing);
        end
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      if_req[n] = 1'b0;
      dx_req[n] = 1'b0;
    end
    test_reset();
    test_single_fetch();
    test_write_read();
    test_contention(0);
    test_contention(1);
    test_read_lat3();
    test_reset_mid_op();
    test_back_to_back(0);
    test_back_to_back(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
